// File: rtl/ssd1306_command_framebuffer_pkg.sv
// Shared opcodes, widths and FSM encoding for the SSD1306 command/framebuffer front end.
package ssd1306_defs;

  localparam int COL_W  = 7;
  localparam int PAGE_W = 3;
  localparam int ADDR_W = COL_W + PAGE_W;

  localparam logic [7:0] CMD_SET_COLUMN  = 8'h21;
  localparam logic [7:0] CMD_SET_PAGE    = 8'h22;
  localparam logic [7:0] CMD_CONTRAST    = 8'h81;
  localparam logic [7:0] CMD_ENTIRE_OFF  = 8'hA4;
  localparam logic [7:0] CMD_ENTIRE_ON   = 8'hA5;
  localparam logic [7:0] CMD_NORMAL      = 8'hA6;
  localparam logic [7:0] CMD_INVERT      = 8'hA7;
  localparam logic [7:0] CMD_DISPLAY_OFF = 8'hAE;
  localparam logic [7:0] CMD_DISPLAY_ON  = 8'hAF;
  localparam logic [7:0] CMD_PAGE_BASE   = 8'hB0;

  typedef enum logic [2:0] {
    CLEAR,
    IDLE,
    COL_A,
    COL_B,
    PAGE_A,
    PAGE_B,
    CONTRAST
  } state_e;

endpackage

// File: rtl/ssd1306_command_framebuffer_if.sv
// Byte-stream handshake between the SSD1306 command source and the framebuffer front end.
interface ssd1306_command_framebuffer_if;
  logic [7:0] Byte_i;
  logic       DataCommand_i;
  logic       Valid_i;
  logic       Ready_o;

  modport master (output Byte_i, output DataCommand_i, output Valid_i, input Ready_o);
  modport slave  (input Byte_i, input DataCommand_i, input Valid_i, output Ready_o);
endinterface

// File: rtl/ssd1306_command_framebuffer_ram.sv
// 1024x8 simple dual-port framebuffer RAM: synchronous write, registered read-first read.
module framebuffer_ram #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 8
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              WrEn_i,
  input  logic [ADDR_W-1:0] WrAddr_i,
  input  logic [DATA_W-1:0] WrData_i,
  input  logic [ADDR_W-1:0] RdAddr_i,
  output logic [DATA_W-1:0] RdData_o
);

  logic [DATA_W-1:0] mem [2**ADDR_W];
  logic [DATA_W-1:0] rdData_q;

  always_ff @(posedge Clock) begin
    if (WrEn_i) begin
      mem[WrAddr_i] <= WrData_i;
    end
  end

  // Separate read register sees the pre-write contents on a same-address collision.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      rdData_q <= '0;
    end else begin
      rdData_q <= mem[RdAddr_i];
    end
  end

  assign RdData_o = rdData_q;

endmodule

// File: rtl/ssd1306_command_framebuffer.sv
// SSD1306 command decoder writing a 128x64 page-organised framebuffer with a VGA read port.
module ssd1306_command_framebuffer
  import ssd1306_defs::*;
#(
  parameter int         COLUMNS        = 128,
  parameter int         PAGES          = 8,
  parameter logic [7:0] CONTRAST_RESET = 8'h7F,
  parameter bit         CLEAR_ON_RESET = 1'b1
) (
  input  logic                          Clock,
  input  logic                          Reset,
  ssd1306_command_framebuffer_if.slave  bus,
  input  logic [COL_W-1:0]              ReadColumn_i,
  input  logic [PAGE_W-1:0]             ReadPage_i,
  output logic [7:0]                    ReadData_o,
  output logic                          DisplayOn_o,
  output logic                          Invert_o,
  output logic                          EntireOn_o,
  output logic [7:0]                    Contrast_o
);

  localparam int     LAST_ADDR   = COLUMNS * PAGES - 1;
  localparam state_e RESET_STATE = CLEAR_ON_RESET ? CLEAR : IDLE;

  state_e              state_q, state_d;
  logic [COL_W-1:0]    colStart_q, colStart_d, colEnd_q, colEnd_d, col_q, col_d;
  logic [PAGE_W-1:0]   pageStart_q, pageStart_d, pageEnd_q, pageEnd_d, page_q, page_d;
  logic [ADDR_W-1:0]   clearAddr_q, clearAddr_d;
  logic                displayOn_q, displayOn_d, invert_q, invert_d, entireOn_q, entireOn_d;
  logic [7:0]          contrast_q, contrast_d;
  logic                wrEn;
  logic [ADDR_W-1:0]   wrAddr;
  logic [7:0]          wrData;
  logic                accept;

  assign bus.Ready_o = (state_q != CLEAR) && !Reset;
  assign accept      = bus.Valid_i && bus.Ready_o;

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q     <= RESET_STATE;
      colStart_q  <= '0;
      colEnd_q    <= COL_W'(COLUMNS - 1);
      pageStart_q <= '0;
      pageEnd_q   <= PAGE_W'(PAGES - 1);
      col_q       <= '0;
      page_q      <= '0;
      clearAddr_q <= '0;
      displayOn_q <= 1'b0;
      invert_q    <= 1'b0;
      entireOn_q  <= 1'b0;
      contrast_q  <= CONTRAST_RESET;
    end else begin
      state_q     <= state_d;
      colStart_q  <= colStart_d;
      colEnd_q    <= colEnd_d;
      pageStart_q <= pageStart_d;
      pageEnd_q   <= pageEnd_d;
      col_q       <= col_d;
      page_q      <= page_d;
      clearAddr_q <= clearAddr_d;
      displayOn_q <= displayOn_d;
      invert_q    <= invert_d;
      entireOn_q  <= entireOn_d;
      contrast_q  <= contrast_d;
    end
  end

  // A data byte always wins: it aborts any half-received parameter sequence.
  always_comb begin
    state_d     = state_q;
    colStart_d  = colStart_q;
    colEnd_d    = colEnd_q;
    pageStart_d = pageStart_q;
    pageEnd_d   = pageEnd_q;
    col_d       = col_q;
    page_d      = page_q;
    clearAddr_d = clearAddr_q;
    displayOn_d = displayOn_q;
    invert_d    = invert_q;
    entireOn_d  = entireOn_q;
    contrast_d  = contrast_q;
    wrEn        = 1'b0;
    wrAddr      = {page_q, col_q};
    wrData      = bus.Byte_i;

    if (state_q == CLEAR) begin
      wrEn        = 1'b1;
      wrAddr      = clearAddr_q;
      wrData      = '0;
      clearAddr_d = clearAddr_q + 1'b1;
      if (clearAddr_q == ADDR_W'(LAST_ADDR)) begin
        clearAddr_d = '0;
        state_d     = IDLE;
      end
    end else if (accept && bus.DataCommand_i) begin
      wrEn    = 1'b1;
      state_d = IDLE;
      if (col_q == colEnd_q) begin
        col_d  = colStart_q;
        page_d = (page_q == pageEnd_q) ? pageStart_q : page_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end else if (accept) begin
      case (state_q)
        IDLE: begin
          case (bus.Byte_i)
            CMD_SET_COLUMN:  state_d     = COL_A;
            CMD_SET_PAGE:    state_d     = PAGE_A;
            CMD_CONTRAST:    state_d     = CONTRAST;
            CMD_DISPLAY_OFF: displayOn_d = 1'b0;
            CMD_DISPLAY_ON:  displayOn_d = 1'b1;
            CMD_NORMAL:      invert_d    = 1'b0;
            CMD_INVERT:      invert_d    = 1'b1;
            CMD_ENTIRE_OFF:  entireOn_d  = 1'b0;
            CMD_ENTIRE_ON:   entireOn_d  = 1'b1;
            default: begin
              if (bus.Byte_i[7:3] == CMD_PAGE_BASE[7:3]) begin
                page_d = bus.Byte_i[2:0];
              end
            end
          endcase
        end
        COL_A: begin
          colStart_d = bus.Byte_i[6:0];
          state_d    = COL_B;
        end
        COL_B: begin
          colEnd_d = bus.Byte_i[6:0];
          col_d    = colStart_q;
          state_d  = IDLE;
        end
        PAGE_A: begin
          pageStart_d = bus.Byte_i[2:0];
          state_d     = PAGE_B;
        end
        PAGE_B: begin
          pageEnd_d = bus.Byte_i[2:0];
          page_d    = pageStart_q;
          state_d   = IDLE;
        end
        CONTRAST: begin
          contrast_d = bus.Byte_i;
          state_d    = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  framebuffer_ram #(
    .ADDR_W (ADDR_W),
    .DATA_W (8)
  ) u_ram (
    .Clock    (Clock),
    .Reset    (Reset),
    .WrEn_i   (wrEn),
    .WrAddr_i (wrAddr),
    .WrData_i (wrData),
    .RdAddr_i ({ReadPage_i, ReadColumn_i}),
    .RdData_o (ReadData_o)
  );

  assign DisplayOn_o = displayOn_q;
  assign Invert_o    = invert_q;
  assign EntireOn_o  = entireOn_q;
  assign Contrast_o  = contrast_q;

endmodule
